countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
Seconds-resolution countdown timer for the anti-theft alarm FSM. Sits directly downstream of the time-parameter register bank and consumes its 4-bit selected interval `value`. On a start request it loads that value and counts down one unit per second, using an internal prescaler on the system clock. It reports `expired` back to the alarm FSM and exposes `busy`, `remaining` and a 1 Hz tick for status/LED logic.

Parameters:
CYCLES_PER_SEC, 100000000, clock cycles per one-second tick; legal range ≥2; set to 4 in simulation.
PRESC_W, $clog2(CYCLES_PER_SEC), prescaler counter width (derived; not overridden).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start_timer  input  1  load-and-start request, sampled each rising edge.
value  input  4  interval length in seconds, from the parameter bank; sampled only with start_timer.
expired  output  1  registered one-cycle pulse when the countdown reaches 0.
busy  output  1  high while in COUNTING.
remaining  output  4  seconds left (registered).
one_hz_enable  output  1  one-cycle pulse at each second boundary while COUNTING.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; prescaler=0; remaining=0.
  - expired=0, busy=0, one_hz_enable=0.
  - Release is synchronous to the next edge with no extra latency.
- States: IDLE, COUNTING. busy = (state==COUNTING), decoded from a register.
- IDLE:
  - start_timer=1, value=N≥1 → remaining<=N, prescaler<=0, state<=COUNTING.
  - start_timer=1, value=0 → expired<=1 at that edge, state stays IDLE, remaining stays 0.
- COUNTING, per edge:
  - Prescaler increments.
  - When prescaler==CYCLES_PER_SEC-1: prescaler<=0, one_hz_enable<=1 for that one cycle, remaining<=remaining-1.
  - If remaining was 1 at that tick: remaining<=0, expired<=1, state<=IDLE.
- Latency: start sampled at edge 0 with value N → expired high in the cycle after edge N*CYCLES_PER_SEC.
  - Holds for N=0 too (high in the cycle after edge 0).
  - Exactly one cycle wide; never two consecutive cycles unless a new start with value 0 arrives.
- Restart: start_timer in COUNTING has priority over tick and expiry.
  - Reloads remaining=value and clears the prescaler.
  - No expired and no one_hz_enable pulse that cycle, even if a tick or expiry coincided.
- start_timer held high re-arms every cycle, so the timer never expires while start is held (with value≠0).
- remaining never wraps: it decrements only from ≥1 and is held at 0 in IDLE.
- value changes while COUNTING are ignored.
- Reset mid-count aborts immediately: no expired pulse, all outputs go to reset values.
- Widths: remaining and value are 4 bits unsigned (max 15 s); the prescaler compares against CYCLES_PER_SEC-1 in PRESC_W bits.

Optional Feature:
TIMER_PAUSE_EN
- Defined: adds input port `pause` (1 bit).
  - In COUNTING with pause=1 and start_timer=0: prescaler and remaining hold, no one_hz_enable, no expiry; busy stays 1.
  - start_timer overrides pause.
  - pause is ignored in IDLE.
- Undefined: `pause` port absent; counting is never suspended.

Test Plan:
- CYCLES_PER_SEC=4; reset low 3 cycles, release → all outputs 0, state IDLE, remaining=0.
- start with value=3 at edge 0 → busy=1 from edge 0; one_hz_enable pulses after edges 4, 8, 12; remaining 3→2→1→0; expired=1 only in the cycle after edge 12; busy=0 from edge 12.
- start with value=0 → expired=1 in the cycle after the start edge, busy stays 0, no one_hz_enable.
- start value=5, then at edge 10 (remaining=3) start with value=2 → remaining=2, prescaler cleared; expired after edge 18; no pulse at edge 20.
- start value=2, drop reset at edge 6 → all outputs 0 immediately; after release no expired pulse ever appears.
- TIMER_PAUSE_EN: start value=2, pause=1 during edges 2–9 → remaining stays 2; expired after edge 16 instead of edge 8.

Source files
------------

// File: rtl/countdown_timer.sv
// Seconds-resolution countdown timer with an internal clock prescaler and 1 Hz tick.
// Optional TIMER_PAUSE_EN adds a `pause` input that freezes an active countdown.
module countdown_timer #(
    parameter int unsigned CYCLES_PER_SEC = 100000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_timer,
    input  logic [3:0] value,
`ifdef TIMER_PAUSE_EN
    input  logic       pause,
`endif
    output logic       expired,
    output logic       busy,
    output logic [3:0] remaining,
    output logic       one_hz_enable
);

    localparam int unsigned PRESC_W = $clog2(CYCLES_PER_SEC);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CYCLES_PER_SEC - 1);

    localparam logic [0:0] StIdle     = 1'b0;
    localparam logic [0:0] StCounting = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [3:0]         rem_q, rem_d;
    logic               expired_q, expired_d;
    logic               tick_q, tick_d;
    logic               hold;

`ifdef TIMER_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    // A start request wins over pause, tick and expiry; value 0 expires at once.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        rem_d     = rem_q;
        expired_d = 1'b0;
        tick_d    = 1'b0;
        if (start_timer) begin
            presc_d = '0;
            if (value == 4'd0) begin
                state_d   = StIdle;
                rem_d     = 4'd0;
                expired_d = 1'b1;
            end else begin
                state_d = StCounting;
                rem_d   = value;
            end
        end else if (state_q == StCounting && !hold) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                tick_d  = 1'b1;
                rem_d   = rem_q - 4'd1;
                if (rem_q == 4'd1) begin
                    expired_d = 1'b1;
                    state_d   = StIdle;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            presc_q   <= '0;
            rem_q     <= 4'd0;
            expired_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            rem_q     <= rem_d;
            expired_q <= expired_d;
            tick_q    <= tick_d;
        end
    end

    assign expired       = expired_q;
    assign busy          = (state_q == StCounting);
    assign remaining     = rem_q;
    assign one_hz_enable = tick_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random starts,
// compared every cycle against an elapsed-time model of the countdown.
module tb_countdown_timer;

    localparam int C = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start_timer = 1'b0;
    logic [3:0] value = 4'd0;
    logic       pause_s = 1'b0;
    logic       expired, busy, one_hz_enable;
    logic [3:0] remaining;

    int total = 0;
    int bad   = 0;

    // Model: countdown described by loaded length and elapsed counting cycles.
    bit m_busy    = 0;
    bit m_expired = 0;
    bit m_tick    = 0;
    int m_n       = 0;
    int m_elapsed = 0;

    countdown_timer #(.CYCLES_PER_SEC(C)) dut (
        .clock         (clock),
        .reset         (reset),
        .start_timer   (start_timer),
        .value         (value),
`ifdef TIMER_PAUSE_EN
        .pause         (pause_s),
`endif
        .expired       (expired),
        .busy          (busy),
        .remaining     (remaining),
        .one_hz_enable (one_hz_enable)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_rem();
        return m_busy ? (m_n - m_elapsed / C) : 0;
    endfunction

    task automatic model_clear();
        m_busy = 0; m_expired = 0; m_tick = 0; m_n = 0; m_elapsed = 0;
    endtask

    task automatic model_edge(input logic s, input logic [3:0] v);
        bit paused;
        paused = 0;
`ifdef TIMER_PAUSE_EN
        paused = pause_s;
`endif
        m_expired = 0;
        m_tick    = 0;
        if (s) begin
            if (v == 0) begin
                m_busy = 0; m_expired = 1; m_n = 0; m_elapsed = 0;
            end else begin
                m_busy = 1; m_n = int'(v); m_elapsed = 0;
            end
        end else if (m_busy && !paused) begin
            m_elapsed++;
            if (m_elapsed % C == 0) m_tick = 1;
            if (m_elapsed == m_n * C) begin
                m_expired = 1; m_busy = 0;
            end
        end
    endtask

    // One clock edge: drive inputs, advance the model, return at the falling edge.
    task automatic step(input logic s, input logic [3:0] v);
        start_timer = s;
        value       = v;
        @(posedge clock);
        if (reset) model_edge(s, v);
        else model_clear();
        @(negedge clock);
    endtask

    always @(negedge clock) begin
        chk("expired", {7'd0, expired}, {7'd0, m_expired});
        chk("busy", {7'd0, busy}, {7'd0, m_busy});
        chk("one_hz_enable", {7'd0, one_hz_enable}, {7'd0, m_tick});
        chk("remaining", {4'd0, remaining}, 8'(model_rem()));
    end

    initial begin
        repeat (3) @(negedge clock);
        chk("reset_busy", {7'd0, busy}, 8'd0);
        chk("reset_rem", {4'd0, remaining}, 8'd0);
        chk("reset_exp", {7'd0, expired}, 8'd0);
        reset = 1'b1;

        // value 3: ticks after edges 4, 8, 12; expiry after edge 12
        step(1'b1, 4'd3);
        chk("s3_busy0", {7'd0, busy}, 8'd1);
        chk("s3_rem0", {4'd0, remaining}, 8'd3);
        for (int k = 1; k <= 13; k++) begin
            step(1'b0, 4'd0);
            if (k == 4) begin
                chk("s3_tick4", {7'd0, one_hz_enable}, 8'd1);
                chk("s3_rem4", {4'd0, remaining}, 8'd2);
            end
            if (k == 12) begin
                chk("s3_exp12", {7'd0, expired}, 8'd1);
                chk("s3_busy12", {7'd0, busy}, 8'd0);
                chk("s3_rem12", {4'd0, remaining}, 8'd0);
            end
            if (k == 13) chk("s3_exp13", {7'd0, expired}, 8'd0);
        end

        // value 0 expires immediately
        step(1'b1, 4'd0);
        chk("v0_exp", {7'd0, expired}, 8'd1);
        chk("v0_busy", {7'd0, busy}, 8'd0);
        step(1'b0, 4'd0);
        chk("v0_exp_next", {7'd0, expired}, 8'd0);

        // restart value 5 -> value 2 at edge 10, expiry after edge 18
        step(1'b1, 4'd5);
        for (int k = 1; k <= 20; k++) begin
            step(k == 10, (k == 10) ? 4'd2 : 4'd0);
            if (k == 8) chk("rs_rem8", {4'd0, remaining}, 8'd3);
            if (k == 10) chk("rs_rem10", {4'd0, remaining}, 8'd2);
            if (k == 18) chk("rs_exp18", {7'd0, expired}, 8'd1);
            if (k == 20) chk("rs_tick20", {7'd0, one_hz_enable}, 8'd0);
        end

        // restart coinciding with an expiry suppresses pulses
        step(1'b1, 4'd1);
        for (int k = 1; k <= 3; k++) step(1'b0, 4'd0);
        step(1'b1, 4'd3);
        chk("co_exp", {7'd0, expired}, 8'd0);
        chk("co_tick", {7'd0, one_hz_enable}, 8'd0);
        chk("co_rem", {4'd0, remaining}, 8'd3);
        repeat (14) step(1'b0, 4'd0);

        // reset mid-count aborts with no later expiry
        step(1'b1, 4'd2);
        repeat (5) step(1'b0, 4'd0);
        reset = 1'b0;
        #1;
        chk("rm_busy", {7'd0, busy}, 8'd0);
        chk("rm_rem", {4'd0, remaining}, 8'd0);
        model_clear();
        repeat (3) step(1'b0, 4'd0);
        reset = 1'b1;
        repeat (20) step(1'b0, 4'd0);

`ifdef TIMER_PAUSE_EN
        // pause during edges 2..9 pushes expiry from edge 8 to edge 16
        step(1'b1, 4'd2);
        for (int k = 1; k <= 17; k++) begin
            pause_s = (k >= 2 && k <= 9);
            step(1'b0, 4'd0);
            if (k == 8) chk("pz_exp8", {7'd0, expired}, 8'd0);
            if (k == 9) chk("pz_rem9", {4'd0, remaining}, 8'd2);
            if (k == 16) chk("pz_exp16", {7'd0, expired}, 8'd1);
        end
        pause_s = 1'b0;
`endif

        for (int i = 0; i < 1500; i++) begin
`ifdef TIMER_PAUSE_EN
            pause_s = ($urandom_range(0, 3) == 0);
`endif
            step($urandom_range(0, 11) == 0, 4'($urandom_range(0, 15)));
        end
        pause_s = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
